// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with a handshaked decode mode and a
// free-running scan mode for digit multiplexing / row strobing.
module decoder_nto2n_seq #(
  parameter int N          = 2,
  parameter int TICK_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [N-1:0]        a,
  output logic                in_ready,
  output logic [(1<<N)-1:0]   o,
  output logic                o_valid,
  output logic [N-1:0]        o_index,
  output logic                wrap
);

  localparam int W     = 1 << N;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [N-1:0]     IDX_LAST = '1;
  localparam logic [W-1:0]     O_IDLE   = {W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_SCAN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [W-1:0]     o_q, o_d;
  logic             accept;
  logic             tick;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] idx);
    logic [W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] apply_pol(input logic [W-1:0] v);
    return ACTIVE_LOW ? ~v : v;
  endfunction

  assign in_ready = en & ~mode & (state_q != S_SCAN);
  assign accept   = in_valid & in_ready;
  // A tick only counts while scan is being sustained; a mode drop wins over it.
  assign tick     = (state_q == S_SCAN) & en & mode & (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      div_q   <= '0;
      o_q     <= O_IDLE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      div_q   <= div_d;
      o_q     <= o_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mode)          state_d = S_SCAN;
          else if (in_valid) state_d = S_DECODE;
        end
        S_DECODE: if (mode)  state_d = S_SCAN;
        S_SCAN:   if (!mode) state_d = S_IDLE;
        default:             state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    div_d   = div_q;
    wrap_d  = 1'b0;
    case (state_d)
      S_DECODE: begin
        valid_d = 1'b1;
        div_d   = '0;
        if (accept) idx_d = a;
      end
      S_SCAN: begin
        valid_d = 1'b1;
        if (state_q != S_SCAN) begin
          idx_d = '0;
          div_d = '0;
        end else if (tick) begin
          div_d  = '0;
          idx_d  = idx_q + N'(1);
          wrap_d = (idx_q == IDX_LAST);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        idx_d   = '0;
        valid_d = 1'b0;
        div_d   = '0;
      end
    endcase
    o_d = apply_pol(valid_d ? onehot(idx_d) : '0);
  end

  assign o       = o_q;
  assign o_valid = valid_q;
  assign o_index = idx_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Randomised bench for decoder_nto2n_seq: a cycle-count based reference model
// drives expectations for an N=2 instance; a second instance covers ACTIVE_LOW.
module tb_decoder_nto2n_seq;

  localparam int TD  = 3;
  localparam int NP  = 4;     // positions for N=2
  localparam int TD2 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, in_valid;
  logic [1:0] a;
  logic       in_ready;
  logic [3:0] o;
  logic       o_valid;
  logic [1:0] o_index;
  logic       wrap;

  logic       en2, mode2, in_valid2;
  logic [2:0] a2;
  logic       in_ready2;
  logic [7:0] o2;
  logic       o_valid2;
  logic [2:0] o_index2;
  logic       wrap2;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = showing a decoded code, 2 = scanning
  int         m_st;
  int         m_code;
  int         m_cyc;
  logic [3:0] e_o;
  logic       e_v;
  logic [1:0] e_idx;
  logic       e_wrap;

  decoder_nto2n_seq #(.N(2), .TICK_DIV(TD), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .a(a), .in_ready(in_ready), .o(o), .o_valid(o_valid),
    .o_index(o_index), .wrap(wrap)
  );

  decoder_nto2n_seq #(.N(3), .TICK_DIV(TD2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .in_valid(in_valid2),
    .a(a2), .in_ready(in_ready2), .o(o2), .o_valid(o_valid2),
    .o_index(o_index2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic exp_ready();
    return en && !mode && (m_st != 2);
  endfunction

  task automatic model_eval();
    int idx;
    logic [3:0] one;
    one = 4'b0001;
    idx = 0;
    if (m_st == 1) idx = m_code;
    else if (m_st == 2) idx = (m_cyc / TD) % NP;
    e_v    = (m_st != 0);
    e_idx  = 2'(idx);
    e_o    = e_v ? (one << idx) : 4'b0000;
    e_wrap = (m_st == 2) && (m_cyc != 0) && ((m_cyc % (TD * NP)) == 0);
  endtask

  task automatic model_step();
    if (!rst_n || !en) begin
      m_st = 0;
    end else if (m_st == 2) begin
      if (!mode) m_st = 0;
      else       m_cyc++;
    end else if (mode) begin
      m_st  = 2;
      m_cyc = 0;
    end else if (in_valid) begin
      m_st   = 1;
      m_code = int'(a);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; a = '0;
    en2 = 1'b0; mode2 = 1'b0; in_valid2 = 1'b0; a2 = '0;
    m_st = 0; m_cyc = 0; m_code = 0;
    model_eval();
    repeat (2) @(negedge clk);
    checks++;
    if ({o_valid, o_index, o, wrap} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %h exp 00", {o_valid, o_index, o, wrap});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", in_ready);
    end
    checks++;
    if ({o2, o_valid2, o_index2, wrap2} !== {8'hFF, 1'b0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL reset_al got %h exp ff0", {o2, o_valid2, o_index2, wrap2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({o_valid, o_index, o, wrap} !== {e_v, e_idx, e_o, e_wrap}) begin
      errors++; $display("FAIL idle_after_reset got %h exp %h", {o_valid, o_index, o, wrap}, {e_v, e_idx, e_o, e_wrap});
    end
  endtask

  task automatic test_decode();
    logic [3:0] one;
    one = 4'b0001;
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 2'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL decode_ready code %0d got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if ({o_valid, o_index, o} !== {1'b1, 2'(i), one << i}) begin
        errors++; $display("FAIL decode_seq code %0d got %h exp %h", i, {o_valid, o_index, o}, {1'b1, 2'(i), one << i});
      end
    end
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'($urandom_range(0, 1)); a = 2'($urandom);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++; $display("FAIL decode_rand_ready cyc %0d got %b exp %b", i, in_ready, exp_ready());
      end
      tick();
      checks++;
      if ({o_valid, o_index, o, wrap} !== {e_v, e_idx, e_o, e_wrap}) begin
        errors++; $display("FAIL decode_rand cyc %0d got %h exp %h", i, {o_valid, o_index, o, wrap}, {e_v, e_idx, e_o, e_wrap});
      end
    end
  endtask

  task automatic test_hold_disable();
    en = 1'b1; mode = 1'b0; in_valid = 1'b1; a = 2'd2;
    tick();
    in_valid = 1'b0; a = 2'($urandom);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({o_valid, o_index, o} !== {1'b1, 2'd2, 4'b0100} || {o_valid, o_index, o, wrap} !== {e_v, e_idx, e_o, e_wrap}) begin
        errors++; $display("FAIL hold cyc %0d got %h exp %h", i, {o_valid, o_index, o, wrap}, {e_v, e_idx, e_o, e_wrap});
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_index, o, wrap} !== 8'h00) begin
      errors++; $display("FAIL disable got %h exp 00", {o_valid, o_index, o, wrap});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL disable_ready got %b exp 0", in_ready);
    end
  endtask

  task automatic test_scan();
    int nwrap;
    nwrap = 0;
    en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 2 * TD * NP + 3; i++) begin
      in_valid = 1'($urandom_range(0, 1)); a = 2'($urandom);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL scan_ready cyc %0d got %b exp 0", i, in_ready);
      end
      tick();
      if (wrap === 1'b1) nwrap++;
      checks++;
      if ({o_valid, o_index, o, wrap} !== {e_v, e_idx, e_o, e_wrap}) begin
        errors++; $display("FAIL scan cyc %0d got %h exp %h", i, {o_valid, o_index, o, wrap}, {e_v, e_idx, e_o, e_wrap});
      end
    end
    checks++;
    if (nwrap != 2) begin
      errors++; $display("FAIL scan_wrap_count got %0d exp 2", nwrap);
    end
  endtask

  task automatic test_mode_collision();
    int guard;
    guard = 0;
    en = 1'b1; mode = 1'b1; in_valid = 1'b0;
    // Park on the terminal count of the last position so a stray step would wrap.
    while ((m_cyc % (TD * NP)) != (TD * NP - 1) && guard < 2 * TD * NP) begin
      tick();
      guard++;
    end
    checks++;
    if ({o_valid, o_index, o} !== {1'b1, 2'd3, 4'b1000}) begin
      errors++; $display("FAIL collision_setup got %h exp %h", {o_valid, o_index, o}, {1'b1, 2'd3, 4'b1000});
    end
    mode = 1'b0; in_valid = 1'b1; a = 2'd1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL collision_ready_before got %b exp 0", in_ready);
    end
    tick();
    checks++;
    if ({o_valid, o_index, o, wrap} !== 8'h00) begin
      errors++; $display("FAIL collision got %h exp 00", {o_valid, o_index, o, wrap});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL collision_ready_after got %b exp 1", in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 15) != 0);
      mode     = mode ^ ($urandom_range(0, 7) == 0);
      in_valid = 1'($urandom_range(0, 1));
      a        = 2'($urandom);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++; $display("FAIL random_ready cyc %0d got %b exp %b", i, in_ready, exp_ready());
      end
      tick();
      checks++;
      if ({o_valid, o_index, o, wrap} !== {e_v, e_idx, e_o, e_wrap}) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, {o_valid, o_index, o, wrap}, {e_v, e_idx, e_o, e_wrap});
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < TD * NP - 1; i++) tick();
    checks++;
    if ({o_valid, o_index, o, wrap} !== {e_v, e_idx, e_o, e_wrap} || o_valid !== 1'b1) begin
      errors++; $display("FAIL async_pre got %h exp %h", {o_valid, o_index, o, wrap}, {e_v, e_idx, e_o, e_wrap});
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_st = 0;
    model_eval();
    checks++;
    if ({o_valid, o_index, o, wrap} !== 8'h00) begin
      errors++; $display("FAIL async_reset got %h exp 00", {o_valid, o_index, o, wrap});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({o_valid, o_index, o, wrap} !== {1'b1, 2'd0, 4'b0001, 1'b0}) begin
      errors++; $display("FAIL async_restart got %h exp %h", {o_valid, o_index, o, wrap}, {1'b1, 2'd0, 4'b0001, 1'b0});
    end
    for (int i = 0; i < 2 * TD; i++) begin
      tick();
      checks++;
      if ({o_valid, o_index, o, wrap} !== {e_v, e_idx, e_o, e_wrap}) begin
        errors++; $display("FAIL async_resume cyc %0d got %h exp %h", i, {o_valid, o_index, o, wrap}, {e_v, e_idx, e_o, e_wrap});
      end
    end
  endtask

  task automatic test_active_low();
    logic [7:0] one;
    logic [7:0] exp_o;
    int         idx;
    one = 8'b0000_0001;
    en2 = 1'b1; mode2 = 1'b0; in_valid2 = 1'b1; a2 = 3'd5;
    @(posedge clk); #1;
    checks++;
    if ({o2, o_valid2, o_index2} !== {8'b1101_1111, 1'b1, 3'd5}) begin
      errors++; $display("FAIL al_decode got %h exp %h", {o2, o_valid2, o_index2}, {8'b1101_1111, 1'b1, 3'd5});
    end
    in_valid2 = 1'b0; en2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({o2, o_valid2} !== {8'hFF, 1'b0}) begin
      errors++; $display("FAIL al_idle got %h exp %h", {o2, o_valid2}, {8'hFF, 1'b0});
    end
    en2 = 1'b1; mode2 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      idx   = (k / TD2) % 8;
      exp_o = ~(one << idx);
      checks++;
      if ({o2, o_index2, o_valid2, wrap2} !== {exp_o, 3'(idx), 1'b1, 1'((k != 0) && (k % (8 * TD2) == 0))}) begin
        errors++; $display("FAIL al_scan cyc %0d got %h exp %h", k, {o2, o_index2, o_valid2, wrap2}, {exp_o, 3'(idx), 1'b1, 1'((k != 0) && (k % (8 * TD2) == 0))});
      end
    end
    mode2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_hold_disable();
    test_scan();
    test_mode_collision();
    test_random();
    test_async_reset();
    test_active_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_nto2n_seq.md
Name: decoder_nto2n_seq

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable. It supports two modes. Decode mode latches an input code through a valid/ready handshake. Scan mode walks the one-hot output through every position at a programmable rate, for display digit multiplexing and row strobing. It sits between control logic and multiplexed output drivers. It replaces hand-written fixed-width combinational decoders.

Parameters:
N, 2, input code width; output width is 2^N; legal range 1..6.
TICK_DIV, 4, clock cycles per scan step in scan mode; legal range 1..65535.
ACTIVE_LOW, 0, 1 inverts o only (deasserted = all ones); all other outputs are unaffected.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  block enable; deassertion overrides everything.
mode  in  1  0 = decode, 1 = scan.
in_valid  in  1  a carries a code to decode.
a  in  N  input code.
in_ready  out  1  block accepts a this cycle.
o  out  2^N  registered one-hot output; polarity set by ACTIVE_LOW.
o_valid  out  1  o holds an asserted one-hot value.
o_index  out  N  binary index of the asserted bit of o.
wrap  out  1  one-cycle pulse when scan index rolls from 2^N-1 to 0.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE; o_valid=0, o_index=0, wrap=0, divider=0.
  - o is all zeros, or all ones if ACTIVE_LOW=1.
- States: IDLE, DECODE, SCAN. Priority order is reset, then en=0, then mode change, then scan tick.
- Output law: whenever o_valid=1, o has exactly one asserted bit, at o_index. Whenever o_valid=0, o is fully deasserted.
- in_ready = en & ~mode & (state != SCAN). It is combinational from state and inputs.
- IDLE:
  - en & ~mode & in_valid: go to DECODE. o_index<=a, o_valid<=1.
  - en & mode: go to SCAN. o_index<=0, o_valid<=1, divider<=0.
  - Otherwise stay in IDLE.
- DECODE:
  - Each accepted a (in_valid & in_ready) updates o/o_index on the next edge. Latency is 1 cycle.
  - Back-to-back codes are accepted every cycle.
  - With no in_valid, o holds its value.
  - en=0: go to IDLE next edge, o_valid<=0, o deasserted.
  - mode=1: go to SCAN, o_index<=0, divider<=0. Any in_valid in that cycle is ignored because in_ready=0.
- SCAN:
  - The divider counts 0..TICK_DIV-1. At the terminal count the divider returns to 0 and o_index<=o_index+1, modulo 2^N.
  - wrap=1 for the single cycle following the step from 2^N-1 to 0; otherwise wrap=0.
  - TICK_DIV=1: index advances every cycle.
  - mode=0 (with en=1): go to IDLE next edge, o_valid<=0, divider<=0. A mode change in the same cycle as a tick wins; no index step occurs.
  - en=0: go to IDLE, outputs cleared, divider cleared.
- Mid-operation reset: all outputs return to reset values immediately, without waiting for clk.
- N=1 is legal: o is 2 bits and scan alternates 01/10.
- Divider width is ceil(log2(TICK_DIV)), minimum 1 bit. No overflow is permitted.

Test Plan:
- Reset and decode: N=2, rst_n low then high, en=1, mode=0. Drive in_valid with a=0,1,2,3 on consecutive cycles. Required: o=0001,0010,0100,1000 one cycle after each, o_valid=1, o_index=0..3, in_ready=1 throughout.
- Hold and disable: after a=2, drop in_valid for 5 cycles, then en=0. Required: o holds 0100 for 5 cycles; next edge after en=0 gives o=0000, o_valid=0, state IDLE.
- Scan with TICK_DIV=3, N=2, mode=1:
  - o sequence 0001 x3 cycles, 0010 x3, 0100 x3, 1000 x3, 0001.
  - wrap is high exactly one cycle at the 1000 to 0001 transition.
  - in_ready=0 throughout.
- Mode switch collision: in SCAN, set mode=0 on a terminal-count cycle. Required: no index step; next edge gives o=0000, o_valid=0, IDLE, in_ready=1.
- ACTIVE_LOW=1, N=3, decode a=5. Required: o=8'b1101_1111 after 1 cycle. During reset and IDLE, o=8'hFF.
- Async reset mid-scan: pull rst_n low between clock edges. Required: o, o_valid, o_index and wrap take reset values before the next edge. Scan restarts at index 0 after release with mode=1.
